// File: rtl/spi_temp_reader_pkg.sv
// Shared definitions for the SPI temperature reader.
//   spi_state_t    : frame sequencer states
//   COUNT_WRAP     : last value of the free-running period counter
//   FRAME_BITS_DEF : default number of bits per sensor frame
package spi_temp_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} spi_state_t;

  localparam logic [23:0]  COUNT_WRAP     = 24'd999900;
  localparam int unsigned  FRAME_BITS_DEF = 16;

endpackage

// File: rtl/spi_temp_reader_if.sv
// SPI bus between the temperature reader (master) and the sensor (slave).
//   spi_sclk : SPI clock, CPOL=0, driven by master
//   spi_cs_n : chip select, active-low, driven by master
//   spi_miso : sensor data out, asynchronous to the master clock
interface spi_temp_reader_if;

  logic spi_sclk;
  logic spi_cs_n;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, output spi_miso);

endinterface

// File: rtl/spi_temp_reader_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : asynchronous, active-high; clears both stages to 0
//   d_i : asynchronous input
//   q_o : synchronized output (2 clk latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_temp_reader.sv
// Periodic SPI master read of the temperature sensor.
// A read-only frame starts when the period counter equals TRIG_VALUE while idle.
// FRAME_BITS bits are shifted in MSB first on SCLK rising edges; the completed
// word is presented on temp_data with a one-cycle data_valid strobe.
//   clk, rst   : system clock, asynchronous active-high reset
//   count      : free-running period counter (wraps COUNT_WRAP -> 0)
//   spi        : SPI bus, master side
//   temp_data  : last completed frame, held until the next completes
//   data_valid : 1-cycle pulse when temp_data updates
//   busy       : high from cs_n fall until the completion cycle
//   overrun    : 1-cycle pulse when a trigger arrives while not idle
module spi_temp_reader
  import spi_temp_pkg::*;
#(
  parameter logic [23:0] TRIG_VALUE = 24'd0,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:0]           count,
  spi_temp_reader_if.master     spi,
  output logic [FRAME_BITS-1:0] temp_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(FRAME_BITS);

  spi_state_t            state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] temp_q, temp_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  miso_sync;
  logic                  trig;
  logic                  div_end;

  sync_2ff u_miso_sync (
    .clk (clk),
    .rst (rst),
    .d_i (spi.spi_miso),
    .q_o (miso_sync)
  );

  // A trigger value beyond the counter wrap can never match.
  assign trig    = (TRIG_VALUE <= COUNT_WRAP) && (count == TRIG_VALUE);
  assign div_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      temp_q    <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      temp_q    <= temp_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    temp_d    = temp_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    overrun_d = trig && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          shreg_d = '0;
        end
      end
      SETUP, SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          // SETUP always ends in the first rising edge; SHIFT alternates.
          if (state_q == SETUP || !sclk_q) begin
            state_d = SHIFT;
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], miso_sync};
            bit_d   = bit_q + 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BITS_LAST) begin
              state_d = DONE;
              cs_n_d  = 1'b1;
              busy_d  = 1'b0;
              temp_d  = shreg_q;
              valid_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi.spi_sclk = sclk_q;
  assign spi.spi_cs_n = cs_n_q;
  assign temp_data    = temp_q;
  assign data_valid   = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_temp_reader.sv
// Bench for spi_temp_reader: three instances share one count stimulus
//   dut0 : defaults (TRIG 0, CLK_DIV 4, 16 bits)
//   dut1 : TRIG 999900, defaults otherwise
//   dut2 : TRIG 0, CLK_DIV 3, 12 bits
// Each has a sensor model shifting a preset word out on SCLK falling edges.
// Expected outputs come from the frame timeline: for a trigger in cycle T,
// offset o = c - T gives cs_n/busy/sclk/valid directly.
module tb_spi_temp_reader;

  localparam int NONE = -1000000;

  logic        clk;
  logic        rst;
  logic [23:0] count;

  spi_temp_reader_if sif0 ();
  spi_temp_reader_if sif1 ();
  spi_temp_reader_if sif2 ();

  logic [15:0] t0, t1;
  logic [11:0] t2;
  logic [2:0]  valid_w, busy_w, ovr_w;
  logic [2:0]  sclk_w, cs_w, miso_w;
  logic [15:0] temp_w [3];
  logic [15:0] sens_word [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int          st [3];
  int          oc [3];
  logic [15:0] mw [3];
  logic [15:0] te [3];
  logic [15:0] next_word [3];

  spi_temp_reader #(.TRIG_VALUE(24'd0), .CLK_DIV(4), .FRAME_BITS(16)) u_dut0 (
    .clk(clk), .rst(rst), .count(count), .spi(sif0), .temp_data(t0),
    .data_valid(valid_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0]));

  spi_temp_reader #(.TRIG_VALUE(24'd999900), .CLK_DIV(4), .FRAME_BITS(16)) u_dut1 (
    .clk(clk), .rst(rst), .count(count), .spi(sif1), .temp_data(t1),
    .data_valid(valid_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1]));

  spi_temp_reader #(.TRIG_VALUE(24'd0), .CLK_DIV(3), .FRAME_BITS(12)) u_dut2 (
    .clk(clk), .rst(rst), .count(count), .spi(sif2), .temp_data(t2),
    .data_valid(valid_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2]));

  assign sclk_w[0] = sif0.spi_sclk;
  assign sclk_w[1] = sif1.spi_sclk;
  assign sclk_w[2] = sif2.spi_sclk;
  assign cs_w[0]   = sif0.spi_cs_n;
  assign cs_w[1]   = sif1.spi_cs_n;
  assign cs_w[2]   = sif2.spi_cs_n;
  assign sif0.spi_miso = miso_w[0];
  assign sif1.spi_miso = miso_w[1];
  assign sif2.spi_miso = miso_w[2];
  assign temp_w[0] = t0;
  assign temp_w[1] = t1;
  assign temp_w[2] = {4'h0, t2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sensor models: MSB presented at cs_n fall, next bit on each SCLK fall.
  for (genvar g = 0; g < 3; g++) begin : g_sensor
    localparam int NB = (g == 2) ? 12 : 16;
    int   idx       = 0;
    logic m         = 1'b0;
    logic cs_prev   = 1'b1;
    logic sclk_prev = 1'b0;
    assign miso_w[g] = m;
    always @(cs_w[g] or sclk_w[g]) begin
      if (cs_prev === 1'b1 && cs_w[g] === 1'b0) begin
        idx = NB - 1;
        m   = sens_word[g][idx];
      end else if (cs_w[g] === 1'b0 && sclk_prev === 1'b1 && sclk_w[g] === 1'b0 && idx > 0) begin
        idx = idx - 1;
        m   = sens_word[g][idx];
      end
      cs_prev   = cs_w[g];
      sclk_prev = sclk_w[g];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // SCLK period on the wrap-triggered instance
  longint last_rise1 = 0;
  always @(posedge sclk_w[1]) begin
    if (cs_w[1] === 1'b0 && last_rise1 > 0)
      check_val("sclk1_period", 32'($time - last_rise1), 32'd80);
    last_rise1 = $time;
  end

  function automatic int div_of(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic int nb_of(input int i);
    return (i == 2) ? 12 : 16;
  endfunction

  function automatic logic [23:0] trig_of(input int i);
    return (i == 1) ? 24'd999900 : 24'd0;
  endfunction

  function automatic logic [23:0] rnd_cnt();
    return 24'($urandom_range(1, 999899));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      st[i] = NONE;
      oc[i] = -1;
      te[i] = '0;
    end
  endtask

  task automatic check_all(input int c);
    for (int i = 0; i < 3; i++) begin
      int o, d, f;
      o = c - st[i];
      d = div_of(i);
      f = 2 * d * nb_of(i);
      if (o == f + 1) te[i] = mw[i];
      check_val($sformatf("cs_n%0d", i),  32'(cs_w[i]),    32'(!(o >= 1 && o <= f)));
      check_val($sformatf("busy%0d", i),  32'(busy_w[i]),  32'(o >= 1 && o <= f));
      check_val($sformatf("sclk%0d", i),  32'(sclk_w[i]),
                32'(o >= 1 + d && o <= f && (((o - 1) / d) % 2) == 1));
      check_val($sformatf("valid%0d", i), 32'(valid_w[i]), 32'(o == f + 1));
      check_val($sformatf("ovr%0d", i),   32'(ovr_w[i]),   32'(oc[i] == c));
      check_val($sformatf("temp%0d", i),  32'(temp_w[i]),  32'(te[i]));
    end
  endtask

  task automatic model_trig(input int c, input logic [23:0] cv);
    for (int i = 0; i < 3; i++) begin
      int o, f;
      o = c - st[i];
      f = 2 * div_of(i) * nb_of(i);
      if (cv == trig_of(i)) begin
        if (o >= 1 && o <= f + 1) begin
          oc[i] = c + 1;
        end else begin
          st[i]        = c;
          mw[i]        = (i == 2) ? (next_word[i] & 16'h0FFF) : next_word[i];
          sens_word[i] = mw[i];
        end
      end
    end
  endtask

  task automatic step_cycle(input logic [23:0] cv);
    @(negedge clk);
    check_all(cyc);
    count = cv;
    model_trig(cyc, cv);
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step_cycle(rnd_cnt());
  endtask

  task automatic rand_words();
    for (int i = 0; i < 3; i++) next_word[i] = 16'($urandom);
  endtask

  task automatic apply_reset(input int hold);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst_cs_n%0d", i), 32'(cs_w[i]),   32'd1);
      check_val($sformatf("rst_sclk%0d", i), 32'(sclk_w[i]), 32'd0);
      check_val($sformatf("rst_temp%0d", i), 32'(temp_w[i]), 32'd0);
      check_val($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
    end
    model_reset();
    idle_cycles(hold);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] cv;
    rst   = 1'b1;
    count = 24'd5;
    for (int i = 0; i < 3; i++) begin
      sens_word[i] = '0;
      next_word[i] = '0;
      mw[i]        = '0;
    end
    model_reset();
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(2);

    // Preset words, single trigger
    next_word[0] = 16'hA5C3;
    next_word[1] = 16'h1234;
    next_word[2] = 16'h07E1;
    step_cycle(24'd0);
    idle_cycles(140);
    check_val("t1_word0", 32'(t0), 32'h0000A5C3);
    check_val("t1_word2", 32'(t2), 32'h000007E1);

    // All ones then a single one, back to back
    next_word[0] = 16'hFFFF;
    next_word[2] = 16'h0FFF;
    step_cycle(24'd0);
    idle_cycles(135);
    check_val("t2_ones0", 32'(t0), 32'h0000FFFF);
    next_word[0] = 16'h0001;
    next_word[2] = 16'h0001;
    step_cycle(24'd0);
    idle_cycles(135);
    check_val("t2_one0", 32'(t0), 32'h00000001);

    // Retrigger mid-frame at T+40
    rand_words();
    step_cycle(24'd0);
    idle_cycles(39);
    step_cycle(24'd0);
    idle_cycles(100);

    // Reset mid-frame, then a clean frame
    rand_words();
    step_cycle(24'd0);
    idle_cycles(60);
    apply_reset(10);
    rand_words();
    step_cycle(24'd0);
    idle_cycles(140);

    // Random gaps, random words, triggers held 1..3 cycles
    repeat (10) begin
      idle_cycles($urandom_range(0, 180));
      rand_words();
      repeat ($urandom_range(1, 3)) step_cycle(24'd0);
    end
    idle_cycles(140);

    // Real counter across the wrap
    rand_words();
    cv = 24'd999700;
    repeat (400) begin
      step_cycle(cv);
      cv = (cv == 24'd999900) ? 24'd0 : cv + 24'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
